cordic_arbiter: RTL and testbench

Round-robin arbiter and sequencer that time-shares one sine/CORDIC core among `NUM_CH` tone channels. It accepts per-channel phase/amplitude requests and issues exactly one start strobe to the core. It waits for the core's valid strobe and routes the result back to the granted channel. It sits between the per-channel phase accumulators and the single `sin_generator`-style core.

---
 rtl/wave_gen_pkg.sv | 9 +
 rtl/cordic_arbiter_if.sv | 32 +++
 rtl/cordic_arbiter_rr_arbiter.sv | 24 ++
 rtl/cordic_arbiter.sv | 127 ++++++++++++
 tb/tb_cordic_arbiter.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/wave_gen_pkg.sv
// wave_gen_pkg: shared FSM state encoding and default word format for the tone generator.
package wave_gen_pkg;
  localparam int N_FRAC_DEF = 7;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_e;
endpackage

// File: rtl/cordic_arbiter_if.sv
// cordic_arbiter_if: channel-request and core-handshake bundle of the CORDIC arbiter.
interface cordic_arbiter_if
  import wave_gen_pkg::*;
#(
  parameter int N_FRAC = N_FRAC_DEF,
  parameter int NUM_CH = 4
);
  localparam int W = N_FRAC + 1;
  logic [NUM_CH-1:0]   req_i;
  logic [NUM_CH*W-1:0] phase_i;
  logic [NUM_CH*W-1:0] amplitude_i;
  logic [NUM_CH-1:0]   grant_o;
  logic [W-1:0]        core_phase_o;
  logic [W-1:0]        core_amplitude_o;
  logic                core_start_strobe_o;
  logic [W-1:0]        core_data_i;
  logic                core_valid_strobe_i;
  logic [W-1:0]        data_o;
  logic [NUM_CH-1:0]   data_valid_o;
  logic                busy_o;
  logic                timeout_o;
  modport slave (
    input  req_i, phase_i, amplitude_i, core_data_i, core_valid_strobe_i,
    output grant_o, core_phase_o, core_amplitude_o, core_start_strobe_o,
    output data_o, data_valid_o, busy_o, timeout_o
  );
  modport master (
    output req_i, phase_i, amplitude_i, core_data_i, core_valid_strobe_i,
    input  grant_o, core_phase_o, core_amplitude_o, core_start_strobe_o,
    input  data_o, data_valid_o, busy_o, timeout_o
  );
endinterface

// File: rtl/cordic_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, searching ptr+1, ptr+2, ... modulo NUM_CH.
module rr_arbiter #(
  parameter int NUM_CH = 4
) (
  input  logic [NUM_CH-1:0]         req,
  input  logic [$clog2(NUM_CH)-1:0] ptr,
  output logic [NUM_CH-1:0]         gnt,
  output logic [$clog2(NUM_CH)-1:0] idx,
  output logic                      any
);
  localparam int IW = $clog2(NUM_CH);
  logic [IW-1:0] c;
  // walk from farthest to nearest so the closest requester after ptr wins
  always_comb begin
    idx = '0;
    c   = '0;
    for (int k = NUM_CH; k >= 1; k--) begin
      c = IW'((int'(ptr) + k) % NUM_CH);
      if (req[c]) idx = c;
    end
  end
  assign any = |req;
  assign gnt = any ? NUM_CH'(1) << idx : '0;
endmodule

// File: rtl/cordic_arbiter.sv
// cordic_arbiter: round-robin sequencer time-sharing one CORDIC core among NUM_CH channels.
// Define CORDIC_ARB_TIMEOUT_EN to build the watchdog on the core response.
module cordic_arbiter
  import wave_gen_pkg::*;
#(
  parameter int N_FRAC         = N_FRAC_DEF,
  parameter int NUM_CH         = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic             clk_i,
  input  logic             rst_i,
  cordic_arbiter_if.slave  bus
);
  localparam int W  = N_FRAC + 1;
  localparam int IW = $clog2(NUM_CH);
  if (NUM_CH < 2 || NUM_CH > 8 || TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_param
    $error("cordic_arbiter: parameter out of range");
  end
  state_e            state_q, state_d;
  logic [IW-1:0]     ptr_q, ptr_d, idx_q, idx_d;
  logic [NUM_CH-1:0] gnt_q, gnt_d, dv_q, dv_d;
  logic [W-1:0]      phase_q, phase_d, amp_q, amp_d, data_q, data_d;
  logic [NUM_CH-1:0] arb_gnt;
  logic [IW-1:0]     arb_idx;
  logic              arb_any;
  logic [W-1:0]      ph [NUM_CH];
  logic [W-1:0]      am [NUM_CH];
  for (genvar g = 0; g < NUM_CH; g++) begin : g_unpack
    assign ph[g] = bus.phase_i[g*W +: W];
    assign am[g] = bus.amplitude_i[g*W +: W];
  end
  rr_arbiter #(.NUM_CH(NUM_CH)) u_rr (
    .req (bus.req_i),
    .ptr (ptr_q),
    .gnt (arb_gnt),
    .idx (arb_idx),
    .any (arb_any)
  );
`ifdef CORDIC_ARB_TIMEOUT_EN
  logic [7:0] cnt_q, cnt_d;
  logic       timeout_q, timeout_d;
  assign bus.timeout_o = timeout_q;
`else
  assign bus.timeout_o = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    gnt_d   = gnt_q;
    phase_d = phase_q;
    amp_d   = amp_q;
    data_d  = data_q;
    dv_d    = '0;
`ifdef CORDIC_ARB_TIMEOUT_EN
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
`endif
    case (state_q)
      IDLE: if (arb_any) begin
        state_d = ISSUE;
        idx_d   = arb_idx;
        gnt_d   = arb_gnt;
        phase_d = ph[arb_idx];
        amp_d   = am[arb_idx];
      end
      ISSUE: begin
        state_d = WAIT;
        ptr_d   = idx_q;
`ifdef CORDIC_ARB_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      WAIT: if (bus.core_valid_strobe_i) begin
        state_d = IDLE;
        data_d  = bus.core_data_i;
        dv_d    = gnt_q;
      end
`ifdef CORDIC_ARB_TIMEOUT_EN
      // a strobe in the expiry cycle takes the branch above and wins
      else if (cnt_q == 8'(TIMEOUT_CYCLES)) begin
        state_d   = IDLE;
        data_d    = '0;
        dv_d      = gnt_q;
        timeout_d = 1'b1;
      end else cnt_d = cnt_q + 8'd1;
`endif
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      ptr_q   <= IW'(NUM_CH - 1);
      idx_q   <= '0;
      gnt_q   <= '0;
      phase_q <= '0;
      amp_q   <= '0;
      data_q  <= '0;
      dv_q    <= '0;
`ifdef CORDIC_ARB_TIMEOUT_EN
      cnt_q     <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      gnt_q   <= gnt_d;
      phase_q <= phase_d;
      amp_q   <= amp_d;
      data_q  <= data_d;
      dv_q    <= dv_d;
`ifdef CORDIC_ARB_TIMEOUT_EN
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
`endif
    end
  end
  assign bus.grant_o             = state_q == ISSUE ? gnt_q : '0;
  assign bus.core_start_strobe_o = state_q == ISSUE;
  assign bus.busy_o              = state_q != IDLE;
  assign bus.core_phase_o        = phase_q;
  assign bus.core_amplitude_o    = amp_q;
  assign bus.data_o              = data_q;
  assign bus.data_valid_o        = dv_q;
endmodule

// File: tb/tb_cordic_arbiter.sv
// tb_cordic_arbiter: scoreboard bench; stimulus pushes expected grants/results, a monitor pops and compares.
module tb_cordic_arbiter;
  localparam int NF = 7;
  localparam int NC = 4;
  localparam int TO = 10;
  localparam int W  = NF + 1;
  typedef struct {int ch; logic [7:0] a; logic [7:0] b; logic t;} exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  cordic_arbiter_if #(.N_FRAC(NF), .NUM_CH(NC)) bus ();
  cordic_arbiter #(.N_FRAC(NF), .NUM_CH(NC), .TIMEOUT_CYCLES(TO)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );
  exp_t gq[$];
  exp_t rq[$];
  exp_t me;
  int glog[$];
  int checks = 0;
  int errors = 0;
  int last = NC - 1;
  logic [7:0] ph [NC];
  logic [7:0] am [NC];

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", n, act, req);
    end
  endtask

  // reference round robin: first requester after the last granted channel
  function automatic int pick(input logic [NC-1:0] m);
    for (int k = 1; k <= NC; k++) if (m[(last + k) % NC]) return (last + k) % NC;
    return -1;
  endfunction

  initial forever begin
    @(negedge clk);
    if (!rst) begin
      if (bus.grant_o != 0 || bus.core_start_strobe_o) begin
        if (gq.size() == 0) chk("unexpected_grant", {bus.grant_o, bus.core_start_strobe_o}, 0);
        else begin
          me = gq.pop_front();
          chk("grant", bus.grant_o, 1 << me.ch);
          chk("start", bus.core_start_strobe_o, 1);
          chk("busy_issue", bus.busy_o, 1);
          chk("core_phase", bus.core_phase_o, me.a);
          chk("core_amp", bus.core_amplitude_o, me.b);
          glog.push_back(me.ch);
        end
      end
      if (bus.data_valid_o != 0 || bus.timeout_o) begin
        if (rq.size() == 0) chk("unexpected_result", {bus.data_valid_o, bus.timeout_o}, 0);
        else begin
          me = rq.pop_front();
          chk("data_valid", bus.data_valid_o, 1 << me.ch);
          chk("data", bus.data_o, me.a);
          chk("timeout", bus.timeout_o, me.t);
          chk("idle_after_result", bus.busy_o, 0);
        end
      end
    end
  end

  task automatic chk_zero(input string n);
    chk({n, "_grant"}, bus.grant_o, 0);
    chk({n, "_start"}, bus.core_start_strobe_o, 0);
    chk({n, "_busy"}, bus.busy_o, 0);
    chk({n, "_phase"}, bus.core_phase_o, 0);
    chk({n, "_amp"}, bus.core_amplitude_o, 0);
    chk({n, "_data"}, bus.data_o, 0);
    chk({n, "_dv"}, bus.data_valid_o, 0);
    chk({n, "_timeout"}, bus.timeout_o, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    last = NC - 1;
  endtask

  task automatic drive_data(input bit rnd);
    for (int c = 0; c < NC; c++) begin
      if (rnd) begin
        ph[c] = 8'($urandom_range(1, 255));
        am[c] = 8'($urandom_range(1, 255));
      end
      bus.phase_i[c*W +: W]     = ph[c];
      bus.amplitude_i[c*W +: W] = am[c];
    end
  endtask

  task automatic wait_grant();
    int i;
    bit got;
    got = 1'b0;
    i = 0;
    while (!got && i < 20) begin
      @(negedge clk);
      i++;
      got = bus.grant_o != 0;
    end
    chk("grant_seen", got, 1);
    chk("grant_latency", i, 1);
  endtask

  // lat > 0: core answers lat cycles after start; lat < 0: core never answers
  task automatic txn(input logic [NC-1:0] m, input int lat, input logic [7:0] val,
                     input bit hold, input bit spur, input bit rnd);
    int w;
    int n;
    drive_data(rnd);
    w = pick(m);
    last = w;
    gq.push_back('{w, ph[w], am[w], 1'b0});
    if (lat > 0) rq.push_back('{w, val, 8'h00, 1'b0});
`ifdef CORDIC_ARB_TIMEOUT_EN
    else rq.push_back('{w, 8'h00, 8'h00, 1'b1});
`endif
    bus.req_i = m;
    wait_grant();
    if (!hold) bus.req_i = '0;
    bus.core_valid_strobe_i = spur;
    bus.core_data_i = ~val;
    if (lat > 0) begin
      repeat (lat) begin
        @(negedge clk);
        bus.core_valid_strobe_i = 1'b0;
      end
      bus.core_valid_strobe_i = 1'b1;
      bus.core_data_i = val;
      @(negedge clk);
      bus.core_valid_strobe_i = 1'b0;
      chk("result_seen", bus.data_valid_o != 0, 1);
    end else begin
`ifdef CORDIC_ARB_TIMEOUT_EN
      n = 0;
      do begin
        @(negedge clk);
        bus.core_valid_strobe_i = 1'b0;
        n++;
      end while (bus.data_valid_o == 0 && n < 300);
      chk("timeout_latency", n, TO + 2);
`else
      n = 0;
      repeat (100) begin
        @(negedge clk);
        bus.core_valid_strobe_i = 1'b0;
        n += int'(bus.busy_o);
      end
      chk("busy_held", n, 100);
`endif
    end
  endtask

  task automatic mid_reset();
    drive_data(1'b1);
    last = pick(4'b0001);
    gq.push_back('{last, ph[last], am[last], 1'b0});
    bus.req_i = 4'b0001;
    wait_grant();
    bus.req_i = '0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    last = NC - 1;
    bus.core_valid_strobe_i = 1'b1;
    bus.core_data_i = 8'hAA;
    chk_zero("mid_reset");
    @(negedge clk);
    bus.core_valid_strobe_i = 1'b0;
    chk("late_strobe_dv", bus.data_valid_o, 0);
    chk("late_strobe_busy", bus.busy_o, 0);
  endtask

  initial begin
    int s;
    bus.req_i = '0;
    bus.phase_i = '0;
    bus.amplitude_i = '0;
    bus.core_data_i = '0;
    bus.core_valid_strobe_i = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk_zero("reset");
    ph[0] = 8'h20;
    am[0] = 8'h7F;
    for (int c = 1; c < NC; c++) begin
      ph[c] = 8'(c);
      am[c] = 8'(c);
    end
    txn(4'b0001, 4, 8'h55, 1'b0, 1'b0, 1'b0);
    bus.core_valid_strobe_i = 1'b1;
    bus.core_data_i = 8'h3C;
    @(negedge clk);
    bus.core_valid_strobe_i = 1'b0;
    chk("spur_idle_busy", bus.busy_o, 0);
    @(negedge clk);
    chk("spur_idle_busy2", bus.busy_o, 0);
    txn(4'b0010, 2, 8'h81, 1'b0, 1'b1, 1'b1);
    do_reset();
    s = glog.size();
    for (int i = 0; i < 8; i++) txn(4'b1111, $urandom_range(1, 5), 8'($urandom), i < 7, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) chk("fair_order", glog.size() > s + i ? glog[s + i] : -1, i % NC);
    mid_reset();
    txn(4'b0100, 3, 8'h42, 1'b0, 1'b0, 1'b1);
    repeat (20) begin
      logic [NC-1:0] m;
      m = NC'($urandom_range(1, (1 << NC) - 1));
      txn(m, $urandom_range(1, 6), 8'($urandom), 1'b0, 1'($urandom), 1'b1);
    end
    txn(4'b1000, TO + 1, 8'h6D, 1'b0, 1'b0, 1'b1);
    txn(4'b0010, -1, 8'h00, 1'b0, 1'b0, 1'b1);
    do_reset();
    chk_zero("final_reset");
    repeat (5) @(negedge clk);
    chk("grants_drained", gq.size(), 0);
    chk("results_drained", rq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
